clk_div_prog: RTL and testbench

- Multi-channel, run-time programmable frequency divider. Generalises the team's fixed-N 1 kHz→4 Hz divider.
- Each of NCH channels produces a 50%-duty divided clock level plus a one-cycle tick strobe.
- The divisor of each channel is reloadable through a load/ack handshake and takes effect glitch-free.
- Feeds elevator timing: door timer, floor-travel timer and display blink, all from one 1 kHz clock.

---
 rtl/clk_div_prog.sv | 112 +++++++++++
 tb/tb_clk_div_prog.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel programmable divider: each channel toggles clk_out and strobes tick every N+1
// enabled cycles. New N values are staged through a load/ack handshake and applied glitch-free.
module clk_div_prog #(
  parameter int NCH       = 3,
  parameter int WIDTH     = 16,
  parameter int DEFAULT_N = 124,
  parameter int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             load,
  input  logic [CW-1:0]    load_ch,
  input  logic [WIDTH-1:0] load_val,
  output logic             load_ack,
  output logic             load_err,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [CW:0]      NCH_LIM = (CW + 1)'(NCH);
  localparam logic [WIDTH-1:0] RESET_N = WIDTH'(DEFAULT_N);

  logic load_ok;
  logic ack_q, err_q;

  assign load_ok  = ({1'b0, load_ch} < NCH_LIM);
  assign load_ack = ack_q;
  assign load_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= load & load_ok;
      err_q <= load & ~load_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [CW-1:0] IDX = CW'(gi);

      logic             sel;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] n_q, n_d;
      logic [WIDTH-1:0] pend_val_q, pend_val_d;
      logic             pend_q, pend_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;

      assign sel = load & (load_ch == IDX);

      always_comb begin
        cnt_d      = cnt_q;
        n_d        = n_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        if (en[gi]) begin
          if (cnt_q == n_q) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
            // Swap N only at the terminal event, so no shortened half period is ever produced.
            if (pend_q) begin
              n_d    = pend_val_q;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else if (pend_q) begin
          // Idle channel: no output activity to protect, take the new N straight away.
          n_d    = pend_val_q;
          pend_d = 1'b0;
          cnt_d  = '0;
        end
        // A capture this cycle is only seen by the apply logic from the next cycle onward.
        if (sel) begin
          pend_val_d = load_val;
          pend_d     = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q      <= '0;
          n_q        <= RESET_N;
          pend_val_q <= '0;
          pend_q     <= 1'b0;
          clk_q      <= 1'b0;
          tick_q     <= 1'b0;
        end else begin
          cnt_q      <= cnt_d;
          n_q        <= n_d;
          pend_val_q <= pend_val_d;
          pend_q     <= pend_d;
          clk_q      <= clk_d;
          tick_q     <= tick_d;
        end
      end

      assign clk_out[gi] = clk_q;
      assign tick[gi]    = tick_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed plus randomized bench for clk_div_prog; a cycles-remaining reference model
// predicts every output on every clock.
module tb_clk_div_prog;

  localparam int NCH       = 3;
  localparam int WIDTH     = 16;
  localparam int DEFAULT_N = 124;
  localparam int CW        = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic             load;
  logic [CW-1:0]    load_ch;
  logic [WIDTH-1:0] load_val;
  logic             load_ack, load_err;
  logic [NCH-1:0]   clk_out, tick;

  clk_div_prog #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_N(DEFAULT_N)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_ch(load_ch), .load_val(load_val),
    .load_ack(load_ack), .load_err(load_err), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model state: enabled cycles left until the next toggle, active N, staged N.
  int             m_left [NCH];
  int             m_n    [NCH];
  int             m_pv   [NCH];
  bit             m_pf   [NCH];
  logic [NCH-1:0] m_clk, m_tick;
  logic           m_ack, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_n[i]    = DEFAULT_N;
      m_left[i] = DEFAULT_N + 1;
      m_pv[i]   = 0;
      m_pf[i]   = 1'b0;
    end
    m_clk  = '0;
    m_tick = '0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      m_tick[i] = 1'b0;
      if (en[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
          if (m_pf[i]) begin
            m_n[i]  = m_pv[i];
            m_pf[i] = 1'b0;
          end
          m_left[i] = m_n[i] + 1;
        end
      end else if (m_pf[i]) begin
        m_n[i]    = m_pv[i];
        m_pf[i]   = 1'b0;
        m_left[i] = m_n[i] + 1;
      end
    end
    m_ack = load && (int'(load_ch) < NCH);
    m_err = load && (int'(load_ch) >= NCH);
    if (m_ack) begin
      m_pv[int'(load_ch)] = int'(load_val);
      m_pf[int'(load_ch)] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("load_ack", 32'(load_ack), 32'(m_ack));
    chk("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic do_load(input int ch, input int val);
    load     = 1'b1;
    load_ch  = CW'(ch);
    load_val = WIDTH'(val);
    step();
    load = 1'b0;
    $display("load ch=%0d val=%0d ack=%0b err=%0b", ch, val, load_ack, load_err);
  endtask

  task automatic wait_toggle(input int ch, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < 1000);
    if (!tick[ch]) begin
      compared++;
      mismatched++;
      $error("FAIL wait_toggle ch%0d: no tick within %0d cycles", ch, n);
    end
  endtask

  int n;
  int prev;

  initial begin
    rst      = 1'b1;
    en       = '1;
    load     = 1'b0;
    load_ch  = '0;
    load_val = '0;
    model_reset();
    step();
    step();
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    rst = 1'b0;

    // Default N=124: first rise after 125 cycles, then 125-cycle half periods.
    wait_toggle(0, n);
    chk("first_rise_cycles", n, 125);
    chk("first_rise_level", 32'(clk_out[0]), 32'd1);
    wait_toggle(0, n);
    chk("default_half_period", n, 125);
    $display("default half period ch0=%0d", n);

    // Load ch1 with N=3 while disabled.
    en = 3'b101;
    step();
    do_load(1, 3);
    chk("ch1_ack", 32'(load_ack), 32'd1);
    step();
    chk("ch1_ack_one_cycle", 32'(load_ack), 32'd0);
    en = 3'b111;
    wait_toggle(1, n);
    chk("ch1_first_half", n, 4);
    wait_toggle(1, n);
    chk("ch1_half", n, 4);
    $display("ch1 half period after load=%0d", n);

    // Load ch0 with N=9 at count 50 while running.
    wait_toggle(0, n);
    repeat (50) step();
    do_load(0, 9);
    wait_toggle(0, n);
    chk("ch0_old_half_tail", n, 74);
    wait_toggle(0, n);
    chk("ch0_new_half_a", n, 10);
    wait_toggle(0, n);
    chk("ch0_new_half_b", n, 10);
    $display("ch0 half period after reload=%0d", n);

    // Two loads to ch2: last writer wins.
    wait_toggle(2, n);
    do_load(2, 5);
    chk("ch2_ack_a", 32'(load_ack), 32'd1);
    do_load(2, 7);
    chk("ch2_ack_b", 32'(load_ack), 32'd1);
    wait_toggle(2, n);
    wait_toggle(2, n);
    chk("ch2_half_last_writer", n, 8);
    $display("ch2 half period after double load=%0d", n);

    // Out-of-range channel.
    do_load(3, 2);
    chk("err_pulse", 32'(load_err), 32'd1);
    chk("err_no_ack", 32'(load_ack), 32'd0);
    step();
    chk("err_one_cycle", 32'(load_err), 32'd0);

    // Pause ch0 for 20 cycles mid-count.
    wait_toggle(0, n);
    repeat (3) step();
    prev = int'(clk_out[0]);
    en[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("pause_hold", 32'(clk_out[0]), 32'(prev));
      chk("pause_no_tick", 32'(tick[0]), 32'd0);
    end
    en[0] = 1'b1;
    wait_toggle(0, n);
    chk("pause_stretch", 3 + 20 + n, 30);
    $display("ch0 stretched half period=%0d", 3 + 20 + n);

    // Async reset mid-count with a pending load.
    do_load(1, 20);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_clk_out", 32'(clk_out), 32'd0);
    chk("async_rst_ack", 32'(load_ack), 32'd0);
    step();
    step();
    rst = 1'b0;
    wait_toggle(0, n);
    chk("post_rst_half", n, 125);
    chk("post_rst_all_toggle", 32'(clk_out), 32'd7);

    // Randomized enables and loads.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(7) != 0);
      load     = ($urandom_range(7) == 0);
      load_ch  = CW'($urandom_range(3));
      load_val = WIDTH'($urandom_range(15));
      step();
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
